// File: rtl/glyph_pkg.sv
// Shared types and constants for the digit-glyph recogniser.
// States, result codes and endpoint limit used by glyph_classifier.
package glyph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [3:0] RES_D0     = 4'd0;
    localparam logic [3:0] RES_D1     = 4'd1;
    localparam logic [3:0] RES_D2     = 4'd2;
    localparam logic [3:0] RES_D3     = 4'd3;
    localparam logic [3:0] RES_D4     = 4'd4;
    localparam logic [3:0] RES_D5     = 4'd5;
    localparam logic [3:0] RES_D6     = 4'd6;
    localparam logic [3:0] RES_D7     = 4'd7;
    localparam logic [3:0] RES_D8     = 4'd8;
    localparam logic [3:0] RES_D9     = 4'd9;
    localparam logic [3:0] RES_REJECT = 4'hF;

    localparam int MAX_EP = 4;

endpackage

// File: rtl/glyph_row_scan.sv
// First/last set column and span encoder for one bitmap row.
// Purely combinational; span is 0 for an empty row.
module glyph_row_scan
    import glyph_pkg::*;
#(
    parameter int COLS = 8,
    parameter int CW   = $clog2(COLS)
) (
    input  logic [COLS-1:0] i_row,
    output logic [CW-1:0]   o_first,
    output logic [CW-1:0]   o_last,
    output logic [CW:0]     o_span,
    output logic            o_nz
);

    // Priority-encode both ends of the row and derive the span.
    always_comb begin
        o_first = '0;
        o_last  = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (i_row[i]) o_first = CW'(i);
        end
        for (int i = 0; i < COLS; i++) begin
            if (i_row[i]) o_last = CW'(i);
        end
        o_nz = |i_row;
        if (o_nz)
            o_span = {1'b0, o_last} - {1'b0, o_first}
                   + (CW+1)'(1);
        else
            o_span = '0;
    end

endmodule

// File: rtl/glyph_classifier.sv
// Streamed digit-glyph recogniser with start/done handshake.
// Optional macro GLYPH_STATS_EN exposes registered feature copies.
module glyph_classifier
    import glyph_pkg::*;
#(
    parameter int ROWS     = 12,
    parameter int COLS     = 8,
    parameter int THIN_MAX = 3,
    parameter int NEAR_MAX = 2,
    parameter int RW       = $clog2(ROWS),
    parameter int CW       = $clog2(COLS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [2:0]           i_ep_cnt,
    input  logic [MAX_EP*RW-1:0] i_ep_row,
    input  logic [MAX_EP*CW-1:0] i_ep_col,
    input  logic                 i_row_valid,
    input  logic [COLS-1:0]      i_row_data,
    output logic                 o_row_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [3:0]           o_result,
    output logic                 o_result_valid
`ifdef GLYPH_STATS_EN
    ,
    output logic [CW:0]          o_stat_max_span,
    output logic [RW:0]          o_stat_rises,
    output logic [CW:0]          o_stat_top_span
`endif
);

    localparam int CTR = COLS / 2;
    localparam logic [RW-1:0] LP_LAST_ROW = RW'(ROWS - 1);
    localparam logic [RW-1:0] LP_HALF_ROW = RW'(ROWS / 2);
    localparam logic [CW-1:0] LP_C38      = CW'((3 * COLS) / 8);
    localparam logic [CW:0]   LP_THIN     = (CW+1)'(THIN_MAX);
    localparam logic [RW-1:0] LP_NEAR_R   = RW'(NEAR_MAX);
    localparam logic [CW-1:0] LP_NEAR_C   = CW'(NEAR_MAX);
    localparam logic [RW:0]   LP_TWO      = (RW+1)'(2);

    state_t r_state;
    state_t w_next;

    logic [2:0]           r_ep_cnt;
    logic [MAX_EP*RW-1:0] r_ep_row;
    logic [MAX_EP*CW-1:0] r_ep_col;
    logic [RW-1:0]        r_row_cnt;

    logic [CW:0] r_max_span;
    logic [CW:0] r_top_span;
    logic        r_any_px;
    logic [RW:0] r_rises;
    logic        r_prev_ctr;

    logic [3:0] r_result;
    logic       r_result_valid;
    logic [3:0] w_class;

    logic w_start_acc;
    logic w_row_acc;
    logic w_last_row;
    logic w_ctr;

    logic [CW-1:0] w_first;
    logic [CW-1:0] w_last;
    logic [CW:0]   w_span;
    logic          w_nz;

    logic [RW-1:0] w_ep0r;
    logic [RW-1:0] w_ep1r;
    logic [RW-1:0] w_ep2r;
    logic [CW-1:0] w_ep0c;
    logic [CW-1:0] w_ep2c;
    logic [CW-1:0] w_ep3c;
    logic [RW-1:0] w_dr;
    logic [CW-1:0] w_dc;
    logic          w_unused;

    glyph_row_scan #(
        .COLS (COLS),
        .CW   (CW)
    ) u_scan (
        .i_row   (i_row_data),
        .o_first (w_first),
        .o_last  (w_last),
        .o_span  (w_span),
        .o_nz    (w_nz)
    );

    assign w_start_acc = (r_state == ST_IDLE) && i_start;
    assign w_row_acc   = i_row_valid && o_row_ready;
    assign w_last_row  = (r_row_cnt == LP_LAST_ROW);
    assign w_ctr       = i_row_data[CTR];

    assign w_ep0r = r_ep_row[0*RW +: RW];
    assign w_ep1r = r_ep_row[1*RW +: RW];
    assign w_ep2r = r_ep_row[2*RW +: RW];
    assign w_ep0c = r_ep_col[0*CW +: CW];
    assign w_ep2c = r_ep_col[2*CW +: CW];
    assign w_ep3c = r_ep_col[3*CW +: CW];

    assign w_dr = (w_ep0r >= w_ep2r) ? (w_ep0r - w_ep2r)
                                     : (w_ep2r - w_ep0r);
    assign w_dc = (w_ep0c >= w_ep2c) ? (w_ep0c - w_ep2c)
                                     : (w_ep2c - w_ep0c);

    // ep1 column and ep3 row never take part in a decision.
    assign w_unused = ^{r_ep_row[3*RW +: RW],
                        r_ep_col[1*CW +: CW]};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:     if (i_start) w_next = ST_LOAD;
            ST_LOAD:     if (w_row_acc && w_last_row)
                             w_next = ST_CLASSIFY;
            ST_CLASSIFY: w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        o_row_ready = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        unique case (1'b1)
            (r_state == ST_IDLE): o_busy      = 1'b0;
            (r_state == ST_LOAD): o_row_ready = 1'b1;
            (r_state == ST_DONE): o_done      = 1'b1;
            default:              o_busy      = 1'b1;
        endcase
    end

    // Job latch and on-the-fly row features.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ep_cnt   <= '0;
            r_ep_row   <= '0;
            r_ep_col   <= '0;
            r_row_cnt  <= '0;
            r_max_span <= '0;
            r_top_span <= '0;
            r_any_px   <= 1'b0;
            r_rises    <= '0;
            r_prev_ctr <= 1'b0;
        end else if (w_start_acc) begin
            r_ep_cnt   <= i_ep_cnt;
            r_ep_row   <= i_ep_row;
            r_ep_col   <= i_ep_col;
            r_row_cnt  <= '0;
            r_max_span <= '0;
            r_top_span <= '0;
            r_any_px   <= 1'b0;
            r_rises    <= '0;
            r_prev_ctr <= 1'b0;
        end else if (w_row_acc) begin
            if (!w_last_row)
                r_row_cnt <= r_row_cnt + RW'(1);
            if (w_span > r_max_span)
                r_max_span <= w_span;
            if (w_nz && !r_any_px)
                r_top_span <= w_span;
            if (w_nz)
                r_any_px <= 1'b1;
            if (w_ctr && !r_prev_ctr)
                r_rises <= r_rises + (RW+1)'(1);
            r_prev_ctr <= w_ctr;
        end
    end

    // Decision tree over the accumulated features.
    always_comb begin
        w_class = RES_REJECT;
        if (r_any_px) begin
            case (r_ep_cnt)
                3'd0: begin
                    if (r_rises >= LP_TWO) w_class = RES_D8;
                    else                   w_class = RES_D0;
                end
                3'd2: begin
                    if (r_max_span <= LP_THIN)
                        w_class = RES_D1;
                    else if (w_ep0r < LP_HALF_ROW &&
                             w_ep1r < LP_HALF_ROW)
                        w_class = RES_D9;
                    else if (w_ep0r < LP_HALF_ROW)
                        w_class = RES_D2;
                    else if (r_top_span > LP_THIN)
                        w_class = RES_D3;
                    else
                        w_class = RES_D6;
                end
                3'd4: begin
                    if (w_dr <= LP_NEAR_R && w_dc <= LP_NEAR_C)
                        w_class = (w_ep3c < LP_C38) ? RES_D5
                                                    : RES_D7;
                    else
                        w_class = RES_D4;
                end
                default: w_class = RES_REJECT;
            endcase
        end
    end

    // Result register: cleared on a new job, loaded entering DONE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (w_start_acc) begin
            r_result_valid <= 1'b0;
        end else if (r_state == ST_CLASSIFY) begin
            r_result       <= w_class;
            r_result_valid <= 1'b1;
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;

`ifdef GLYPH_STATS_EN
    logic [CW:0] r_stat_max_span;
    logic [RW:0] r_stat_rises;
    logic [CW:0] r_stat_top_span;

    // Snapshot of the features of the job just finished.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stat_max_span <= '0;
            r_stat_rises    <= '0;
            r_stat_top_span <= '0;
        end else if (r_state == ST_DONE) begin
            r_stat_max_span <= r_max_span;
            r_stat_rises    <= r_rises;
            r_stat_top_span <= r_top_span;
        end
    end

    assign o_stat_max_span = r_stat_max_span;
    assign o_stat_rises    = r_stat_rises;
    assign o_stat_top_span = r_stat_top_span;
`endif

endmodule

// File: tb/tb_glyph_classifier.sv
// Self-checking bench for glyph_classifier at default parameters.
// Directed glyphs followed by random jobs against a reference model.
module tb_glyph_classifier;

    localparam int ROWS = 12;
    localparam int COLS = 8;
    localparam int RW   = 4;
    localparam int CW   = 3;

    logic            i_clk;
    logic            i_rst;
    logic            i_start;
    logic [2:0]      i_ep_cnt;
    logic [4*RW-1:0] i_ep_row;
    logic [4*CW-1:0] i_ep_col;
    logic            i_row_valid;
    logic [COLS-1:0] i_row_data;
    logic            o_row_ready;
    logic            o_busy;
    logic            o_done;
    logic [3:0]      o_result;
    logic            o_result_valid;

    int n_tests;
    int n_fail;
    logic [3:0] last_res;
    logic [COLS-1:0] g [ROWS];
    int ep_r [4];
    int ep_c [4];

    glyph_classifier dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_ep_cnt       (i_ep_cnt),
        .i_ep_row       (i_ep_row),
        .i_ep_col       (i_ep_col),
        .i_row_valid    (i_row_valid),
        .i_row_data     (i_row_data),
        .o_row_ready    (o_row_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_result       (o_result),
        .o_result_valid (o_result_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ep(input int r0, input int c0,
                          input int r1, input int c1,
                          input int r2, input int c2,
                          input int r3, input int c3);
        ep_r[0] = r0; ep_c[0] = c0;
        ep_r[1] = r1; ep_c[1] = c1;
        ep_r[2] = r2; ep_c[2] = c2;
        ep_r[3] = r3; ep_c[3] = c3;
    endtask

    task automatic fill(input logic [COLS-1:0] v);
        for (int r = 0; r < ROWS; r++) g[r] = v;
    endtask

    task automatic drive_ep();
        for (int k = 0; k < 4; k++) begin
            i_ep_row[k*RW +: RW] = RW'(ep_r[k]);
            i_ep_col[k*CW +: CW] = CW'(ep_c[k]);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference: features from the row list, then the digit rules.
    function automatic logic [3:0] model(input int cnt);
        int any, maxs, tops, rises, prev, lo, hi, sp, cb;
        any = 0; maxs = 0; tops = 0; rises = 0; prev = 0;
        for (int r = 0; r < ROWS; r++) begin
            lo = -1; hi = -1;
            for (int c = 0; c < COLS; c++)
                if (g[r][c]) begin
                    if (lo < 0) lo = c;
                    hi = c;
                end
            sp = (lo < 0) ? 0 : hi - lo + 1;
            if (sp > maxs) maxs = sp;
            if (sp > 0 && any == 0) tops = sp;
            if (sp > 0) any = 1;
            cb = int'(g[r][COLS/2]);
            if (cb == 1 && prev == 0) rises++;
            prev = cb;
        end
        if (any == 0) return 4'hF;
        if (cnt == 0) return (rises >= 2) ? 4'd8 : 4'd0;
        if (cnt == 2) begin
            if (maxs <= 3) return 4'd1;
            if (ep_r[0] < ROWS/2 && ep_r[1] < ROWS/2) return 4'd9;
            if (ep_r[0] < ROWS/2) return 4'd2;
            return (tops > 3) ? 4'd3 : 4'd6;
        end
        if (cnt == 4) begin
            if (absd(ep_r[0], ep_r[2]) <= 2 &&
                absd(ep_c[0], ep_c[2]) <= 2)
                return (ep_c[3] < (3*COLS)/8) ? 4'd5 : 4'd7;
            return 4'd4;
        end
        return 4'hF;
    endfunction

    // One job from a negedge with the block idle; ends idle.
    task automatic run_job(input int cnt, input logic [3:0] exp,
                           input bit gap, input bit poke,
                           input string tag);
        i_start  = 1'b1;
        i_ep_cnt = 3'(cnt);
        drive_ep();
        @(negedge i_clk);
        i_start = 1'b0;
        chk({tag, "_valid_clr"}, o_result_valid, 0);
        chk({tag, "_busy"}, o_busy, 1);
        chk({tag, "_hold_prev"}, o_result, last_res);
        for (int r = 0; r < ROWS; r++) begin
            if (gap) begin
                i_row_valid = 1'b0;
                i_row_data  = COLS'($urandom);
                @(negedge i_clk);
            end
            if (poke && r == 3) begin
                i_start  = 1'b1;
                i_ep_row = 16'hBBBB;
                i_ep_col = 12'h777;
            end
            chk({tag, "_ready"}, o_row_ready, 1);
            i_row_valid = 1'b1;
            i_row_data  = g[r];
            @(negedge i_clk);
            i_start = 1'b0;
            drive_ep();
        end
        i_row_valid = 1'b0;
        chk({tag, "_done_early"}, o_done, 0);
        chk({tag, "_ready_low"}, o_row_ready, 0);
        chk({tag, "_res_keep"}, o_result, last_res);
        @(negedge i_clk);
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_result"}, o_result, exp);
        chk({tag, "_valid"}, o_result_valid, 1);
        @(negedge i_clk);
        chk({tag, "_done_pulse"}, o_done, 0);
        chk({tag, "_idle"}, o_busy, 0);
        chk({tag, "_res_hold"}, o_result, exp);
        last_res = exp;
    endtask

    initial begin
        int cnt;
        int cnt_tab [8];
        n_tests = 0;
        n_fail  = 0;
        last_res = 4'd0;
        cnt_tab = '{0, 2, 4, 0, 2, 4, 3, 5};
        i_rst = 1'b0;
        i_start = 1'b0;
        i_ep_cnt = '0;
        i_ep_row = '0;
        i_ep_col = '0;
        i_row_valid = 1'b0;
        i_row_data = '0;
        repeat (2) @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_row_ready, 0);
        chk("rst_done", o_done, 0);
        chk("rst_result", o_result, 0);
        chk("rst_valid", o_result_valid, 0);
        i_rst = 1'b1;
        @(negedge i_clk);

        fill(8'h18);
        set_ep(0, 3, 11, 3, 0, 0, 0, 0);
        run_job(2, 4'd1, 0, 0, "bar");

        fill(8'h24);
        g[0] = 8'h3C; g[3] = 8'h3C; g[7] = 8'h3C;
        for (int r = 8; r < ROWS; r++) g[r] = 8'h00;
        set_ep(0, 0, 0, 0, 0, 0, 0, 0);
        run_job(0, 4'd8, 1, 0, "ring8");

        fill(8'h24);
        g[0] = 8'h3C; g[11] = 8'h2C;
        run_job(0, 4'd0, 0, 0, "ring0");

        fill(8'h18);
        set_ep(5, 2, 0, 0, 6, 3, 7, 1);
        run_job(4, 4'd5, 0, 1, "ep5");
        set_ep(5, 2, 0, 0, 6, 3, 7, 6);
        run_job(4, 4'd7, 0, 0, "ep7");
        set_ep(5, 2, 0, 0, 9, 3, 7, 1);
        run_job(4, 4'd4, 0, 0, "ep4");

        fill(8'hFF);
        set_ep(2, 0, 3, 0, 0, 0, 0, 0);
        run_job(2, 4'd9, 0, 0, "wide9");
        set_ep(2, 0, 10, 0, 0, 0, 0, 0);
        run_job(2, 4'd2, 1, 0, "wide2");
        g[0] = 8'h1F;
        set_ep(8, 0, 10, 0, 0, 0, 0, 0);
        run_job(2, 4'd3, 0, 0, "wide3");
        g[0] = 8'h00; g[1] = 8'h03;
        run_job(2, 4'd6, 0, 0, "wide6");

        fill(8'h00);
        run_job(2, 4'hF, 0, 0, "empty");
        fill(8'h18);
        run_job(3, 4'hF, 0, 0, "cnt3");

        i_start = 1'b1;
        i_ep_cnt = 3'd2;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int r = 0; r < 7; r++) begin
            i_row_valid = 1'b1;
            i_row_data  = 8'h18;
            @(negedge i_clk);
        end
        i_row_valid = 1'b0;
        i_rst = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ready", o_row_ready, 0);
        chk("mid_rst_result", o_result, 0);
        chk("mid_rst_valid", o_result_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("mid_rst_nodone", o_done, 0);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("post_rst_idle", o_busy, 0);
        last_res = 4'd0;

        for (int j = 0; j < 40; j++) begin
            int zero_all;
            zero_all = ($urandom_range(0, 9) == 0) ? 1 : 0;
            for (int r = 0; r < ROWS; r++) begin
                case ($urandom_range(0, 3))
                    0: g[r] = 8'h00;
                    1: g[r] = 8'(1 << $urandom_range(0, 7));
                    2: g[r] = 8'($urandom & $urandom);
                    default: g[r] = 8'($urandom);
                endcase
                if (zero_all == 1) g[r] = 8'h00;
            end
            for (int k = 0; k < 4; k++) begin
                ep_r[k] = $urandom_range(0, ROWS - 1);
                ep_c[k] = $urandom_range(0, COLS - 1);
            end
            if ($urandom_range(0, 1) == 1) begin
                ep_r[2] = ep_r[0] + $urandom_range(0, 3);
                if (ep_r[2] > ROWS - 1) ep_r[2] = ROWS - 1;
                ep_c[2] = ep_c[0] - $urandom_range(0, 2);
                if (ep_c[2] < 0) ep_c[2] = 0;
            end
            cnt = cnt_tab[$urandom_range(0, 7)];
            run_job(cnt, model(cnt), 1'($urandom_range(0, 1)),
                    0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_classifier.md
Name: glyph_classifier

Overview:
- Parametrised digit-glyph recogniser: takes a binarised glyph bitmap row by row, plus up to four stroke endpoints from the endpoint tracer, and returns a digit code 0-9 or a reject code.
- Replaces the fixed 12x8, all-rows-parallel recogniser with a streamed row interface and a start/done handshake.
- Row-span (stroke thickness) and centre-column features are computed on the fly, so there is no per-row storage.

Parameters:
- ROWS, 12, glyph height in rows (4..15).
- COLS, 8, glyph width in columns (4..16).
- THIN_MAX, 3, maximum row span (last-first+1) counted as a thin stroke.
- NEAR_MAX, 2, per-axis distance at or below which two endpoints are "near".
- RW, $clog2(ROWS), row-coordinate width (derived).
- CW, $clog2(COLS), column-coordinate width (derived).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_start  in  1  begin job; endpoint inputs sampled on acceptance
- i_ep_cnt  in  3  number of valid endpoints
- i_ep_row  in  4*RW  endpoint row coords, ep0 in LSBs
- i_ep_col  in  4*CW  endpoint column coords, ep0 in LSBs
- i_row_valid  in  1  row data valid
- i_row_data  in  COLS  bitmap row, bit 0 = leftmost column
- o_row_ready  out  1  block accepts a row
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse, result ready
- o_result  out  4  digit code 0-9, or 4'hF reject
- o_result_valid  out  1  o_result holds a valid code

Behaviour:
- Reset: state IDLE; all outputs 0; all counters and features 0. Reset asserted mid-job abandons the job with no o_done.
- FSM states: IDLE -> LOAD -> CLASSIFY -> DONE -> IDLE.
- IDLE:
  - i_start accepted: latch endpoint count and coordinates, clear features, clear o_result_valid, go to LOAD.
  - i_start is ignored in every other state.
- LOAD:
  - o_row_ready=1. A row is accepted when i_row_valid&&o_row_ready.
  - Per accepted row:
    - compute first/last set column and span (span = last-first+1; 0 if the row is empty);
    - track max_span (CW+1 bits) and top_span (span of the first non-empty row);
    - set any_px if any row is non-empty;
    - increment rises (RW+1 bits) when the centre column (COLS/2) is 1 and was 0 in the previous accepted row. The row before row 0 counts as 0.
  - Row counter does not wrap. On the ROWS-th acceptance go to CLASSIFY; o_row_ready is low from the next cycle.
- CLASSIFY: one cycle, evaluated in this order:
  - !any_px, or i_ep_cnt not in {0,2,4} -> 4'hF.
  - cnt 0: rises>=2 -> 8, else 0.
  - cnt 2:
    - max_span<=THIN_MAX -> 1;
    - else both endpoint rows < ROWS/2 -> 9;
    - else ep0 row < ROWS/2 -> 2;
    - else top_span>THIN_MAX -> 3, else 6.
  - cnt 4: |ep0-ep2| <= NEAR_MAX on both axes -> (ep3 col < 3*COLS/8 ? 5 : 7); else 4.
- Distance arithmetic: absolute differences computed unsigned at RW/CW width, larger minus smaller, never negative.
- DONE: o_done=1 for exactly one cycle. o_result and o_result_valid are set in the same cycle and hold until the next accepted i_start. Return to IDLE.
- Timing and o_busy:
  - o_done occurs 2 cycles after the final row is accepted.
  - o_busy=1 in LOAD, CLASSIFY and DONE.

Optional Feature:
- Macro: GLYPH_STATS_EN.
- Defined: adds output ports o_stat_max_span [CW:0], o_stat_rises [RW:0] and o_stat_top_span [CW:0]. These are registered copies of the features, updated in DONE and reset to 0.
- Undefined: these ports and their registers do not exist; classification is identical.

Decomposition:
- Package glyph_pkg holds:
  - state enum;
  - result constants (RES_REJECT=4'hF, digit codes);
  - MAX_EP=4.
- Sub-module glyph_row_scan: combinational first/last/span encoder for one COLS-wide row, instantiated once in LOAD.

Test Plan (defaults ROWS=12, COLS=8):
- Vertical 2-px bar in all 12 rows, cnt=2, eps (0,3),(11,3) -> max_span=2, o_result=1, o_done 2 cycles after row 11.
- Ring glyph with centre column rising twice, cnt=0 -> 8. Same glyph with one rise -> 0.
- cnt=4, ep0=(5,2), ep2=(6,3), ep3 col=1 -> 5. Same with ep3 col=6 -> 7. Same with ep2=(9,3) -> 4.
- cnt=2, wide rows, eps rows 2 and 3 -> 9. ep rows 2 and 10 -> 2. ep rows 8 and 10 with top_span 5 -> 3; with top_span 2 -> 6.
- Handshake and boundary cases:
  - i_row_valid toggling every other cycle;
  - i_start pulsed during LOAD (must be ignored);
  - all-zero bitmap -> 4'hF;
  - cnt=3 -> 4'hF;
  - i_rst dropped after row 6 -> outputs 0, no o_done.
- Back-to-back jobs: o_result_valid falls on the second i_start, and o_result keeps the first value until the second o_done.
